// File: rtl/xor_checksum.sv
// xor_checksum: folds each frame of WIDTH-bit words into a running XOR and
// presents the checksum, beat count and truncation flag on a valid/ready port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input word handshake
//   in_data, in_last      word to fold, final-beat marker
//   out_valid/out_ready   result handshake
//   out_sum               XOR of all accepted words of the frame
//   out_count             beats in the frame (1..MAX_LEN)
//   out_trunc             frame closed by the MAX_LEN limit rather than in_last
//   out_parity            reduction XOR of out_sum (only with XOR_CHECKSUM_PARITY_EN)
//
// Optional feature macro: XOR_CHECKSUM_PARITY_EN adds the out_parity output.
module xor_checksum #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_LEN = 15,
  localparam int unsigned CW     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CW-1:0]    out_count,
`ifdef XOR_CHECKSUM_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_trunc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CW-1:0]      count_q, count_d;
  logic               trunc_q, trunc_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               accept;

  // in_ready_q mirrors "state is not DONE", so it is a registered decode.
  assign accept = in_valid && in_ready_q;

  // Next-state and next-result computation.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    trunc_d = trunc_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          // First beat of a frame seeds the registers instead of folding.
          sum_d   = (state_q == IDLE) ? in_data : (sum_q ^ in_data);
          count_d = (state_q == IDLE) ? CW'(1) : (count_q + CW'(1));
          if (in_last) begin
            state_d = DONE;
            trunc_d = 1'b0;
          end else if (count_d == CW'(MAX_LEN)) begin
            state_d = DONE;
            trunc_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          sum_d   = '0;
          count_d = '0;
          trunc_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; handshake flags are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      count_q     <= '0;
      trunc_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      trunc_q     <= trunc_d;
      in_ready_q  <= (state_d != DONE);
      out_valid_q <= (state_d == DONE);
    end
  end

`ifdef XOR_CHECKSUM_PARITY_EN
  logic parity_q;

  // Parity tracks the sum register, so it clears and holds with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^sum_d;
    end
  end

  assign out_parity = parity_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_trunc = trunc_q;

endmodule

// File: tb/tb_xor_checksum.sv
// Directed self-checking bench for xor_checksum (WIDTH=4, MAX_LEN=15).
module tb_xor_checksum;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned MAX_LEN = 15;
  localparam int unsigned CW      = $clog2(MAX_LEN + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CW-1:0]    out_count;
  logic             out_trunc;
`ifdef XOR_CHECKSUM_PARITY_EN
  logic             out_parity;
`endif

  int checks;
  int failures;

  xor_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
`ifdef XOR_CHECKSUM_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_trunc (out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat for exactly one edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic v, input logic [3:0] s,
                              input logic [3:0] c, input logic t);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".sum"},   32'(out_sum),   32'(s));
    check({tag, ".count"}, 32'(out_count), 32'(c));
    check({tag, ".trunc"}, 32'(out_trunc), 32'(t));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_result("por", 1'b0, 4'h0, 4'd0, 1'b0);
    check("por.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("por_rel.in_ready", 32'(in_ready), 32'd1);

    // Single beat, result held while out_ready is low.
    send(4'b1000, 1'b1);
    check_result("single", 1'b1, 4'b1000, 4'd1, 1'b0);
    check("single.in_ready", 32'(in_ready), 32'd0);
`ifdef XOR_CHECKSUM_PARITY_EN
    check("single.parity", 32'(out_parity), 32'd1);
`endif
    out_ready = 1'b1;
    step();
    check_result("single_rel", 1'b0, 4'h0, 4'd0, 1'b0);
    check("single_rel.in_ready", 32'(in_ready), 32'd1);

    // Three-beat frame with out_ready held high: result lasts one cycle.
    send(4'b0000, 1'b0);
    send(4'b1000, 1'b0);
    check_result("three_mid", 1'b0, 4'b1000, 4'd2, 1'b0);
    send(4'b0011, 1'b1);
    check_result("three", 1'b1, 4'b1011, 4'd3, 1'b0);
    step();
    check("three_1cyc.valid", 32'(out_valid), 32'd0);
    check("three_1cyc.in_ready", 32'(in_ready), 32'd1);

    // Backpressure: stall 5 cycles while a word is offered.
    out_ready = 1'b0;
    send(4'b0011, 1'b0);
    send(4'b0011, 1'b1);
    check_result("bp", 1'b1, 4'h0, 4'd2, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_result("bp_stall", 1'b1, 4'h0, 4'd2, 1'b0);
      check("bp_stall.in_ready", 32'(in_ready), 32'd0);
    end
    // Release with in_valid still high: the word must not be taken this edge.
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("bp_rel", 1'b0, 4'h0, 4'd0, 1'b0);
    check("bp_rel.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // Truncation at MAX_LEN without in_last.
    for (int i = 0; i < 14; i++) send(4'b0001, 1'b0);
    check_result("trunc_14", 1'b0, 4'b0000, 4'd14, 1'b0);
    send(4'b0001, 1'b0);
    check_result("trunc", 1'b1, 4'b0001, 4'd15, 1'b1);
    out_ready = 1'b1;
    step();
    check_result("trunc_rel", 1'b0, 4'h0, 4'd0, 1'b0);
    out_ready = 1'b0;

    // in_last on the limiting beat is a normal close.
    for (int i = 0; i < 14; i++) send(4'b0000, 1'b0);
    send(4'b0101, 1'b1);
    check_result("limit_last", 1'b1, 4'b0101, 4'd15, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-frame after 2 of 3 beats.
    send(4'b0010, 1'b0);
    send(4'b0110, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_result("rst_mid", 1'b0, 4'h0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_mid_rel.in_ready", 32'(in_ready), 32'd1);
    send(4'b0100, 1'b1);
    check_result("after_rst", 1'b1, 4'b0100, 4'd1, 1'b0);
`ifdef XOR_CHECKSUM_PARITY_EN
    check("after_rst.parity", 32'(out_parity), 32'd1);
`endif

    // Reset while a result is pending discards it.
    #3;
    rst_n = 1'b0;
    #1;
    check_result("rst_done", 1'b0, 4'h0, 4'd0, 1'b0);
    check("rst_done.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_done_rel.valid", 32'(out_valid), 32'd0);

    // Back-to-back single-beat frames: one result every two cycles.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'b0111;
    in_last   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("b2b.valid", 32'(out_valid), 32'((i % 2) == 0));
      check("b2b.in_ready", 32'(in_ready), 32'((i % 2) != 0));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
